// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer with shift commands
// Streams WIDTH-bit words MSB- or LSB-first and drives a universal shift register's mode.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             dir,
  input  logic             pause,
  output logic             ser_out,
  output logic [1:0]       ser_ctrl,
  output logic             busy,
  output logic             done
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_dir_q;
  logic             r_done;
  logic             w_xfer;
  logic             w_last;
  logic             w_advance;

  assign w_last    = (r_cnt == LAST);
  assign w_advance = (r_state == SHIFT) && !pause;
  assign w_xfer    = din_valid && din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = SHIFT;
      SHIFT:   if (w_advance && w_last && !w_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_ready = 1'b0;
    ser_out   = 1'b0;
    ser_ctrl  = 2'b00;
    busy      = 1'b0;
    case (r_state)
      IDLE: din_ready = 1'b1;
      SHIFT: begin
        busy      = 1'b1;
        din_ready = w_last && !pause;
        ser_out   = r_dir_q ? r_sr[0] : r_sr[WIDTH-1];
        if (!pause) ser_ctrl = r_dir_q ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  // Datapath: a load wins over the final shift so back-to-back words need no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_dir_q <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_advance && w_last;
      if (w_xfer) begin
        r_sr    <= din;
        r_dir_q <= dir;
        r_cnt   <= '0;
      end else if (w_advance && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
        r_sr  <= r_dir_q ? {1'b0, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized self-checking bench for piso_serializer
module tb_piso_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         dir;
  logic         pause;
  logic         ser_out;
  logic [1:0]   ser_ctrl;
  logic         busy;
  logic         done;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dir(dir), .pause(pause), .ser_out(ser_out), .ser_ctrl(ser_ctrl),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: a word in flight is just the queue of bits still to be presented.
  logic         m_active;
  logic         m_bits[$];
  logic         m_dir;
  logic [W-1:0] m_cur;
  logic [W-1:0] m_fin;
  logic         m_done;
  logic [W-1:0] ds_reg;

  task automatic model_reset();
    m_active = 1'b0;
    m_bits.delete();
    m_dir  = 1'b0;
    m_done = 1'b0;
    ds_reg = '0;
  endtask

  task automatic step(input logic [W-1:0] d, input logic v, input logic dr, input logic p);
    logic         e_out, e_rdy, xfer, done_n;
    logic [1:0]   e_ctrl;
    logic         s_out;
    logic [1:0]   s_ctrl;
    @(negedge clk);
    din = d; din_valid = v; dir = dr; pause = p;
    #1;
    e_out  = m_active ? m_bits[0] : 1'b0;
    e_ctrl = (m_active && !p) ? (m_dir ? 2'b01 : 2'b10) : 2'b00;
    e_rdy  = !m_active || (m_bits.size() == 1 && !p);
    check("ser_out", ser_out, e_out);
    check("ser_ctrl", ser_ctrl, e_ctrl);
    check("din_ready", din_ready, e_rdy);
    check("busy", busy, m_active);
    check("done", done, m_done);
    if (m_done) check("downstream_word", ds_reg, m_fin);
    s_out = ser_out; s_ctrl = ser_ctrl;
    if (s_ctrl == 2'b10)      ds_reg = {ds_reg[W-2:0], s_out};
    else if (s_ctrl == 2'b01) ds_reg = {s_out, ds_reg[W-1:1]};
    xfer   = v && e_rdy;
    done_n = 1'b0;
    if (m_active && !p) begin
      void'(m_bits.pop_front());
      if (m_bits.size() == 0) begin
        done_n = 1'b1;
        m_fin  = m_cur;
      end
    end
    if (xfer) begin
      m_bits.delete();
      for (int i = 0; i < W; i++) m_bits.push_back(dr ? d[i] : d[W-1-i]);
      m_cur = d; m_dir = dr; m_active = 1'b1;
    end else if (m_active && m_bits.size() == 0) begin
      m_active = 1'b0;
    end
    m_done = done_n;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; dir = 1'b0; pause = 1'b0;
    model_reset();
    #2;
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_ser_ctrl", ser_ctrl, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_din_ready", din_ready, 1'b1);
    check("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;

    // MSB-first and LSB-first single words
    step(4'b1011, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(4'b0000, 0, 0, 0);
    step(4'b1011, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(4'b0000, 0, 0, 0);
    // back-to-back with valid held
    step(4'b1100, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b1100, 1, 0, 0);
    step(4'b0011, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b0011, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    // pause for two cycles after the first bit
    step(4'b1010, 1, 0, 0);
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(4'b0000, 0, 0, 0);
    // mid-word valid/dir/din changes ignored
    step(4'b0110, 1, 0, 0);
    step(4'b1111, 1, 1, 0);
    step(4'b1001, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(4'b0000, 0, 0, 0);

    // asynchronous reset after bit 2
    step(4'b1101, 1, 0, 0);
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("amid_ser_ctrl", ser_ctrl, 2'b00);
    check("amid_ser_out", ser_out, 1'b0);
    check("amid_busy", busy, 1'b0);
    check("amid_din_ready", din_ready, 1'b1);
    model_reset();
    @(posedge clk); #1;
    check("amid_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    step(4'b0111, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(4'b0000, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step(W'($urandom), ($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 12; i++) step(4'b0000, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, word length in bits; SHALL be at least 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 Port: din  input  WIDTH  parallel word to transmit.
REQ-005 Port: din_valid  input  1  din holds a word to send.
REQ-006 Port: din_ready  output  1  block can accept a word; transfer occurs on an edge where din_valid and din_ready are both 1.
REQ-007 Port: dir  input  1  bit order: 0 = MSB first, 1 = LSB first; sampled with the word.
REQ-008 Port: pause  input  1  freezes shifting while high.
REQ-009 Port: ser_out  output  1  current serial bit.
REQ-010 Port: ser_ctrl  output  2  shift command for a downstream universal shift register: 00 hold, 01 right shift (serial in at MSB), 10 left shift (serial in at LSB); 11 SHALL never be driven.
REQ-011 Port: busy  output  1  a word is in transmission.
REQ-012 Port: done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-013 FSM states SHALL be IDLE and SHIFT; internal state SHALL be a WIDTH-bit shift register sr, a bit counter cnt (0..WIDTH-1), and a captured direction dir_q.
REQ-014 din_ready SHALL be 1 in IDLE, and 1 in SHIFT only when cnt==WIDTH-1 and pause==0; otherwise 0.
REQ-015 On a transfer: sr<=din, dir_q<=dir, cnt<=0, state<=SHIFT.
REQ-016 In SHIFT, ser_out SHALL be sr[WIDTH-1] when dir_q==0 and sr[0] when dir_q==1.
REQ-017 In SHIFT with pause==0, ser_ctrl SHALL be 10 (dir_q==0) or 01 (dir_q==1); in IDLE or when pause==1, ser_ctrl SHALL be 00.
REQ-018 In SHIFT with pause==0 and cnt<WIDTH-1: cnt increments; sr shifts left (dir_q==0) or right (dir_q==1), filling with 0.
REQ-019 In SHIFT with pause==1: sr, cnt, dir_q and state SHALL hold; ser_out SHALL keep its value.
REQ-020 At cnt==WIDTH-1 with pause==0: if a transfer occurs, REQ-015 applies (back-to-back, no idle cycle); otherwise state<=IDLE.
REQ-021 done SHALL be registered and high for exactly one cycle, in the cycle after each cycle where cnt==WIDTH-1, state==SHIFT and pause==0, regardless of whether a new word starts.
REQ-022 Latency: word accepted at edge N; bit k SHALL be presented between edges N+k and N+k+1 when no pause occurs; a downstream register fed ser_out/ser_ctrl SHALL hold din after edge N+WIDTH.
REQ-023 busy SHALL equal (state==SHIFT).
REQ-024 din_valid while din_ready==0 SHALL be ignored; changes to dir or din mid-word SHALL have no effect.
REQ-025 In IDLE, ser_out SHALL be 0.

Reset
REQ-026 While rst==1: state=IDLE, sr=0, cnt=0, dir_q=0, done=0; outputs ser_out=0, ser_ctrl=00, busy=0, din_ready=1.
REQ-027 Reset mid-word SHALL abort the word immediately with no done pulse; the first transfer after release SHALL start a fresh word.

Verification (WIDTH=4)
REQ-028 din=1011, dir=0, one transfer -> ser_out 1,0,1,1 on 4 consecutive cycles with ser_ctrl=10, then done=1 for one cycle; a shift-register model fed ser_out/ser_ctrl holds 1011.
REQ-029 din=1011, dir=1 -> ser_out 1,1,0,1 with ser_ctrl=01; model holds 1011.
REQ-030 Words 1100 then 0011, din_valid held, dir=0 -> 8 contiguous shift cycles 1,1,0,0,0,0,1,1; din_ready=1 only in IDLE and on each last bit; done pulses after bit 4 and bit 8.
REQ-031 din=1010, dir=0, pause=1 for 2 cycles after bit 1 -> ser_ctrl=00 and ser_out=0 held for those cycles; word completes in 6 cycles; model holds 1010.
REQ-032 rst=1 asynchronously after bit 2 -> same cycle ser_ctrl=00, ser_out=0, busy=0, din_ready=1; no done; next word transmits correctly.
REQ-033 Mid-word: din_valid=1 with new din, dir toggled -> ignored; current word completes unchanged.
